// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte sources,
// with per-grant burst limit and a watchdog on the serializer's tx_done.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 65536,
  localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [IDW-1:0]       grant_id,
  output logic                 grant_active,
  output logic                 err_timeout
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC);

  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [BCW-1:0] burst_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           last_q;

  logic           sel_valid;
  logic [7:0]     sel_data;
  logic           sel_last;
  logic [IDW-1:0] next_ptr;

  // First valid requester at or after p, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     p);
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(p) + i) % NUM_REQ;
      if (!found && v[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Only the granted requester's lane is ever looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[i*8 +: 8];
        sel_last     = req_last[i];
        req_ready[i] = (state == S_LOAD) && req_valid[i];
      end
    end
  end

  assign next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      burst_cnt    <= '0;
      wd_cnt       <= '0;
      last_q       <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grant_id     <= rr_pick(req_valid, ptr);
            grant_active <= 1'b1;
            state        <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (sel_valid) begin
            tx_data   <= sel_data;
            last_q    <= sel_last;
            burst_cnt <= burst_cnt + BCW'(1);
            state     <= S_START;
          end else begin
            ptr          <= next_ptr;
            grant_active <= 1'b0;
            burst_cnt    <= '0;
            state        <= S_IDLE;
          end
        end

        S_START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            wd_cnt   <= '0;
            state    <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          // tx_done takes priority over a coincident watchdog expiry.
          if (tx_done) begin
            if (last_q || (burst_cnt == BURST_MAX) || !sel_valid) begin
              ptr          <= next_ptr;
              grant_active <= 1'b0;
              burst_cnt    <= '0;
              state        <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end else if (wd_cnt == WD_LAST) begin
            err_timeout  <= 1'b1;
            ptr          <= next_ptr;
            grant_active <= 1'b0;
            burst_cnt    <= '0;
            state        <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: source queues feed requesters, a uart_tx
// model answers tx_start, and a monitor checks each started byte against expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned MAX_BURST   = 16;
  localparam int unsigned TIMEOUT_CYC = 200;
  localparam int unsigned IDW         = 2;
  localparam int          FRAME       = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [IDW-1:0]       grant_id;
  logic                 grant_active;
  logic                 err_timeout;

  logic tx_busy_m;
  logic force_busy;
  logic no_done;

  assign tx_busy = tx_busy_m | force_busy;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MAX_BURST  (MAX_BURST),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .grant_active(grant_active),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [8:0] src_q [NUM_REQ][$];
  int         exp_id[$];
  logic [7:0] exp_data[$];

  int         cyc     = 0;
  int         n_start = 0;
  int         t_start = 0;
  int         n_to    = 0;
  int         t_to    = 0;
  logic       ga_at_to = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] cur_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic src_push(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
  endtask

  task automatic exp_push(input int id, input logic [7:0] d);
    exp_id.push_back(id);
    exp_data.push_back(d);
  endtask

  function automatic bit all_src_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_id.size() == 0 && all_src_empty() && !grant_active && !in_frame) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Requester drivers: present queue heads, pop on sampled handshake.
  initial begin
    logic [NUM_REQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy for FRAME cycles after tx_start, then a 1-cycle tx_done.
  initial begin
    int   cnt;
    logic st, r;
    cnt       = 0;
    tx_busy_m = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      st = tx_start;
      r  = rst;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (r) begin
        cnt       = 0;
        tx_busy_m = 1'b0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_busy_m = 1'b0;
          tx_done   = 1'b1;
        end
      end else if (st && !no_done) begin
        cnt       = FRAME;
        tx_busy_m = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pop on every tx_start, data stability at tx_done, watchdog events.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) in_frame = 1'b0;
      if (tx_start) begin
        n_start++;
        t_start = cyc;
        if (exp_id.size() == 0) begin
          chk("unexpected_tx_start", int'(tx_data), -1);
        end else begin
          chk("grant_id_at_start", int'(grant_id), exp_id.pop_front());
          chk("tx_data_at_start", int'(tx_data), int'(exp_data.pop_front()));
        end
        cur_data = tx_data;
        in_frame = !no_done;
      end else if (tx_done && in_frame) begin
        chk("tx_data_stable_at_done", int'(tx_data), int'(cur_data));
        in_frame = 1'b0;
      end
      if (err_timeout) begin
        n_to++;
        t_to     = cyc;
        ga_at_to = grant_active;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int base, t0;
    bit seen;
    rst        = 1'b1;
    force_busy = 1'b0;
    no_done    = 1'b0;
    idle(3);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_grant_active", int'(grant_active), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    idle(2);

    // 1: single byte, ready one cycle after valid.
    src_push(0, 8'hA5, 1'b1);
    exp_push(0, 8'hA5);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_valid[0]) begin seen = 1'b1; break; end
    end
    chk("t1_valid_seen", int'(seen), 1);
    @(negedge clk);
    chk("t1_ready_latency", int'(req_ready), 1);
    chk("t1_grant_active", int'(grant_active), 1);
    wait_drain("t1_drain", 100);
    chk("t1_grant_id_holds", int'(grant_id), 0);
    chk("t1_tx_data_holds", int'(tx_data), 8'hA5);

    // 2: all four at once, twice (pointer wraps back to 0).
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        src_push(i, 8'(8'h10 * (i + 1) + r), 1'b1);
        exp_push(i, 8'(8'h10 * (i + 1) + r));
      end
      wait_drain("t2_drain", 300);
    end

    // 3: burst limit. Grant req1 once so the pointer sits at 2.
    src_push(1, 8'h90, 1'b1);
    exp_push(1, 8'h90);
    wait_drain("t3_setup_drain", 100);
    for (int k = 0; k < 20; k++) src_push(2, 8'(8'h30 + k), 1'(k == 19));
    src_push(1, 8'h91, 1'b1);
    for (int k = 0; k < 16; k++) exp_push(2, 8'(8'h30 + k));
    exp_push(1, 8'h91);
    for (int k = 16; k < 20; k++) exp_push(2, 8'(8'h30 + k));
    wait_drain("t3_drain", 1000);

    // 4: serializer busy when START is reached.
    force_busy = 1'b1;
    base = n_start;
    src_push(3, 8'hC3, 1'b1);
    exp_push(3, 8'hC3);
    idle(50);
    chk("t4_no_start_while_busy", n_start - base, 0);
    chk("t4_grant_held", int'(grant_active), 1);
    force_busy = 1'b0;
    wait_drain("t4_drain", 100);
    chk("t4_one_start", n_start - base, 1);

    // 5: watchdog expiry, then normal service.
    no_done = 1'b1;
    base    = n_to;
    src_push(0, 8'h5A, 1'b1);
    exp_push(0, 8'h5A);
    seen = 1'b0;
    for (int k = 0; k < 2 * TIMEOUT_CYC; k++) begin
      @(negedge clk);
      if (n_to != base) begin seen = 1'b1; break; end
    end
    chk("t5_timeout_seen", int'(seen), 1);
    chk("t5_timeout_latency", t_to - t_start, TIMEOUT_CYC);
    chk("t5_released_at_timeout", int'(ga_at_to), 0);
    @(negedge clk);
    chk("t5_single_pulse", int'(err_timeout), 0);
    no_done = 1'b0;
    src_push(2, 8'h77, 1'b1);
    exp_push(2, 8'h77);
    wait_drain("t5_drain", 100);
    chk("t5_one_timeout", n_to - base, 1);

    // 6: reset mid-frame; pointer (3 before) returns to 0.
    src_push(1, 8'h66, 1'b1);
    exp_push(1, 8'h66);
    base = n_start;
    t0   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (n_start != base) begin t0 = 1; break; end
    end
    chk("t6_frame_started", t0, 1);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx_start", int'(tx_start), 0);
    chk("t6_rst_tx_data", int'(tx_data), 0);
    chk("t6_rst_grant_id", int'(grant_id), 0);
    chk("t6_rst_grant_active", int'(grant_active), 0);
    chk("t6_rst_req_ready", int'(req_ready), 0);
    rst  = 1'b0;
    base = n_start;
    idle(40);
    chk("t6_no_resend", n_start - base, 0);
    src_push(0, 8'h0A, 1'b1);
    src_push(3, 8'h3A, 1'b1);
    exp_push(0, 8'h0A);
    exp_push(3, 8'h3A);
    wait_drain("t6_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
